// File: rtl/vc_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vc_fifo_pkg
// Description : Shared defaults, reset thresholds and threshold clamp helper
//               for the virtual-channel FIFO.
// Revision    : 1.0
// ============================================================================
package vc_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 6;
    localparam int DEF_ADDR_WIDTH = 2;

    // Almost-empty reset threshold; almost-full resets to DEPTH-1.
    localparam int unsigned TH_AE_RESET = 1;

    function automatic int unsigned reset_th_af(input int unsigned depth);
        return depth - 1;
    endfunction

    function automatic int unsigned clamp_th(input int unsigned th, input int unsigned depth);
        return (th > depth) ? depth : th;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vc_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : vc_fifo_mem
// Description : DEPTH x DATA_WIDTH register array, synchronous write port and
//               registered read port (read data holds when not reading).
// Revision    : 1.0
// ============================================================================
module vc_fifo_mem
    import vc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    always_comb begin
        mem_d = mem_q;
        if (i_we) begin
            mem_d[i_waddr] = i_wdata;
        end
    end

    // Read samples the pre-write contents, so a same-address read/write
    // returns the oldest word.
    always_comb begin
        rdata_d = rdata_q;
        if (i_re) begin
            rdata_d = mem_q[i_raddr];
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign o_rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/vc_fifo_flags.sv
`default_nettype none
// ============================================================================
// Module      : vc_fifo_flags
// Description : Synchronous FIFO with occupancy counter, programmable
//               almost-full/almost-empty thresholds and sticky error flag.
// Revision    : 1.0
// ============================================================================
module vc_fifo_flags
    import vc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic [ADDR_WIDTH:0]   th_almost_full,
    input  logic [ADDR_WIDTH:0]   th_almost_empty,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  fifo_error,
    output logic [ADDR_WIDTH:0]   occupancy
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int          CW    = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         occ_q, occ_d;
    logic [CW-1:0]         th_af_q, th_af_d;
    logic [CW-1:0]         th_ae_q, th_ae_d;
    logic                  error_q, error_d;
    logic                  valid_q, valid_d;
    logic                  w_wr_acc;
    logic                  w_rd_acc;

    // A full FIFO still accepts a write when a read frees a slot on the same edge.
    assign w_wr_acc = wr_en && (!fifo_full || rd_en);
    assign w_rd_acc = rd_en && !fifo_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        th_af_d  = th_af_q;
        th_ae_d  = th_ae_q;
        error_d  = error_q;
        valid_d  = w_rd_acc;

        if (w_wr_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (w_rd_acc) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        end

        case ({w_wr_acc, w_rd_acc})
            2'b10:   occ_d = occ_q + CW'(1);
            2'b01:   occ_d = occ_q - CW'(1);
            default: occ_d = occ_q;
        endcase

        if ((wr_en && !w_wr_acc) || (rd_en && !w_rd_acc)) begin
            error_d = 1'b1;
        end

        if (init) begin
            th_af_d = CW'(clamp_th(32'(th_almost_full), DEPTH));
            th_ae_d = CW'(clamp_th(32'(th_almost_empty), DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            th_af_q  <= CW'(reset_th_af(DEPTH));
            th_ae_q  <= CW'(TH_AE_RESET);
            error_q  <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            th_af_q  <= th_af_d;
            th_ae_q  <= th_ae_d;
            error_q  <= error_d;
            valid_q  <= valid_d;
        end
    end

    vc_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .rst     (reset),
        .i_we    (w_wr_acc),
        .i_waddr (wr_ptr_q),
        .i_wdata (data_in),
        .i_re    (w_rd_acc),
        .i_raddr (rd_ptr_q),
        .o_rdata (data_out)
    );

    assign occupancy    = occ_q;
    assign fifo_empty   = (occ_q == '0);
    assign fifo_full    = (occ_q == CW'(DEPTH));
    assign almost_full  = (occ_q >= th_af_q);
    assign almost_empty = (occ_q <= th_ae_q);
    assign fifo_error   = error_q;
    assign valid_out    = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_vc_fifo_flags.sv
`default_nettype none
// ============================================================================
// Module      : tb_vc_fifo_flags
// Description : Directed and random stimulus against a queue-based model.
// Revision    : 1.0
// ============================================================================
module tb_vc_fifo_flags;

    localparam int DW    = 6;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          init = 1'b0;
    logic [AW:0]   th_almost_full = '0;
    logic [AW:0]   th_almost_empty = '0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          fifo_empty;
    logic          fifo_full;
    logic          almost_full;
    logic          almost_empty;
    logic          fifo_error;
    logic [AW:0]   occupancy;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_q[$];
    int m_th_af = DEPTH - 1;
    int m_th_ae = 1;
    int m_dout  = 0;
    bit m_valid = 1'b0;
    bit m_err   = 1'b0;

    vc_fifo_flags #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk             (clk),
        .reset           (reset),
        .init            (init),
        .th_almost_full  (th_almost_full),
        .th_almost_empty (th_almost_empty),
        .wr_en           (wr_en),
        .data_in         (data_in),
        .rd_en           (rd_en),
        .data_out        (data_out),
        .valid_out       (valid_out),
        .fifo_empty      (fifo_empty),
        .fifo_full       (fifo_full),
        .almost_full     (almost_full),
        .almost_empty    (almost_empty),
        .fifo_error      (fifo_error),
        .occupancy       (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit full, empty, wr_ok, rd_ok;
        if (reset) begin
            m_q.delete();
            m_dout  = 0;
            m_valid = 1'b0;
            m_err   = 1'b0;
            m_th_af = DEPTH - 1;
            m_th_ae = 1;
            return;
        end
        full  = (m_q.size() == DEPTH);
        empty = (m_q.size() == 0);
        wr_ok = wr_en && (!full || rd_en);
        rd_ok = rd_en && !empty;
        if (rd_ok) m_dout = m_q.pop_front();
        if (wr_ok) m_q.push_back(int'(data_in));
        m_valid = rd_ok;
        if ((wr_en && !wr_ok) || (rd_en && !rd_ok)) m_err = 1'b1;
        if (init) begin
            m_th_af = (int'(th_almost_full)  > DEPTH) ? DEPTH : int'(th_almost_full);
            m_th_ae = (int'(th_almost_empty) > DEPTH) ? DEPTH : int'(th_almost_empty);
        end
    endtask

    task automatic step(input bit rst_i, input bit init_i, input bit wr_i, input bit rd_i,
                        input int d_i, input int taf_i, input int tae_i);
        int occ;
        reset           = rst_i;
        init            = init_i;
        wr_en           = wr_i;
        rd_en           = rd_i;
        data_in         = DW'(d_i);
        th_almost_full  = (AW+1)'(taf_i);
        th_almost_empty = (AW+1)'(tae_i);
        @(posedge clk);
        model_edge();
        #1;
        occ = m_q.size();
        chk("occupancy",    int'(occupancy),    occ);
        chk("data_out",     int'(data_out),     m_dout);
        chk("valid_out",    int'(valid_out),    int'(m_valid));
        chk("fifo_error",   int'(fifo_error),   int'(m_err));
        chk("fifo_empty",   int'(fifo_empty),   int'(occ == 0));
        chk("fifo_full",    int'(fifo_full),    int'(occ == DEPTH));
        chk("almost_full",  int'(almost_full),  int'(occ >= m_th_af));
        chk("almost_empty", int'(almost_empty), int'(occ <= m_th_ae));
    endtask

    task automatic wr(input int d);
        step(0, 0, 1, 0, d, 0, 0);
    endtask

    task automatic rd();
        step(0, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset and idle
        do_reset();
        do_reset();
        idle();
        chk("t1_empty", int'(fifo_empty), 1);
        chk("t1_ae", int'(almost_empty), 1);
        chk("t1_error", int'(fifo_error), 0);

        // Fill to full, then overflow
        for (int i = 1; i <= 4; i++) begin
            wr(i);
            chk("t2_occ", int'(occupancy), i);
            chk("t2_af", int'(almost_full), int'(i >= 3));
        end
        chk("t2_full", int'(fifo_full), 1);
        wr(5);
        chk("t2_ovf_err", int'(fifo_error), 1);
        chk("t2_ovf_occ", int'(occupancy), 4);

        // Drain, then underflow
        for (int i = 1; i <= 4; i++) begin
            rd();
            chk("t3_data", int'(data_out), i);
            chk("t3_valid", int'(valid_out), 1);
        end
        chk("t3_empty", int'(fifo_empty), 1);
        rd();
        chk("t3_unf_valid", int'(valid_out), 0);
        chk("t3_unf_hold", int'(data_out), 4);

        // Threshold reprogramming
        do_reset();
        step(0, 1, 0, 0, 0, 2, 0);
        wr(7);
        chk("t4_ae_occ1", int'(almost_empty), 0);
        chk("t4_af_occ1", int'(almost_full), 0);
        wr(8);
        chk("t4_af_occ2", int'(almost_full), 1);
        step(0, 1, 0, 0, 0, 7, 6);
        chk("t4_clamp_ae", int'(almost_empty), 1);
        chk("t4_clamp_af", int'(almost_full), 0);

        // Simultaneous read/write while full, wrap
        do_reset();
        for (int i = 0; i < 4; i++) wr(8'h11 + i);
        step(0, 0, 1, 1, 8'h2A, 0, 0);
        chk("t5_oldest", int'(data_out), 8'h11);
        chk("t5_occ", int'(occupancy), 4);
        chk("t5_err", int'(fifo_error), 0);
        for (int i = 0; i < 4; i++) rd();
        chk("t5_wrap", int'(data_out), 8'h2A);

        // Simultaneous read/write while empty: write only
        step(0, 0, 1, 1, 8'h15, 0, 0);
        chk("t5e_occ", int'(occupancy), 1);
        chk("t5e_valid", int'(valid_out), 0);
        rd();
        chk("t5e_data", int'(data_out), 8'h15);

        // Reset mid-operation, thresholds restored
        do_reset();
        for (int i = 0; i < 3; i++) wr(i + 1);
        step(1, 0, 1, 0, 9, 0, 0);
        chk("t6_occ", int'(occupancy), 0);
        chk("t6_err", int'(fifo_error), 0);
        for (int i = 0; i < 3; i++) wr(i);
        chk("t6_af3", int'(almost_full), 1);

        // Random phase
        for (int n = 0; n < 3000; n++) begin
            int wp, rp;
            wp = (n / 300) % 3 == 0 ? 70 : ((n / 300) % 3 == 1 ? 30 : 50);
            rp = 100 - wp;
            step($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
                 int'($urandom_range(0, 63)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 7)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
